// File: rtl/tile_row_generator.sv
// LFSR-driven tile row source: one row of LANES tile bits per valid/ready handshake,
// with density modes, bounded rejection sampling and a deterministic one-hot fallback.
module tile_row_generator #(
    parameter int                LANES      = 4,
    parameter int                LFSR_W     = 24,
    parameter logic [LFSR_W-1:0] TAPS       = 24'hE10001,
    parameter logic [LFSR_W-1:0] SEED       = 24'h694237,
    parameter int                MAX_ACTIVE = 2,
    parameter int                MAX_TRIES  = 4,
    parameter bit                NO_REPEAT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              entropy_in,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_value,
    input  logic [1:0]        density,
    input  logic              row_ready,
    output logic              row_valid,
    output logic [LANES-1:0]  row,
    output logic [15:0]       rows_issued,
    output logic              fallback_used,
    output logic              dbg_state
);

    // Handshake: a row transfers on a clock edge where row_valid & row_ready;
    // row/fallback_used never change while row_valid is high and row_ready is low.

    localparam int         TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [7:0] LANES8 = 8'(LANES);

    generate
        if (LANES < 2 || LANES > 8 || LFSR_W < 3 * LANES || LFSR_W < 8 ||
            MAX_ACTIVE < 1 || MAX_ACTIVE > LANES || MAX_TRIES < 1 || SEED == '0) begin : g_param_check
            $error("tile_row_generator: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {ST_GEN = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [LFSR_W-1:0]  r_lfsr, w_lfsr_nxt;
    logic [LANES-1:0]   r_row, w_row_nxt;
    logic [LANES-1:0]   r_prev_row, w_prev_nxt;
    logic               r_fallback, w_fallback_nxt;
    logic [TRY_W-1:0]   r_tries, w_tries_nxt;
    logic [15:0]        r_rows_issued, w_issued_nxt;

    logic [LANES-1:0]   w_cand, w_fb_row;
    logic [7:0]         w_hi_idx, w_fb_idx, w_fb_idx_alt;
    logic [3:0]         w_pop;
    logic               w_accept, w_feedback;

    always_comb begin
        w_hi_idx     = r_lfsr[LFSR_W-1 -: 8] % LANES8;
        w_fb_idx     = r_lfsr[7:0] % LANES8;
        w_fb_idx_alt = (w_fb_idx == LANES8 - 8'd1) ? 8'd0 : w_fb_idx + 8'd1;
        w_cand       = '0;
        w_fb_row     = '0;
        w_pop        = '0;
        for (int i = 0; i < LANES; i++) begin
            case (density)
                2'b00:   w_cand[i] = r_lfsr[(3*i) % LFSR_W] & r_lfsr[(3*i+1) % LFSR_W];
                2'b01:   w_cand[i] = r_lfsr[(3*i) % LFSR_W];
                2'b10:   w_cand[i] = r_lfsr[(3*i) % LFSR_W] & r_lfsr[(3*i+1) % LFSR_W]
                                     & r_lfsr[(3*i+2) % LFSR_W];
                default: w_cand[i] = (w_hi_idx == 8'(i));
            endcase
            w_fb_row[i] = (w_fb_idx == 8'(i));
        end
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + {3'b000, w_cand[i]};
        end
        // Step the fallback to the next lane so it can never repeat the previous row.
        if (NO_REPEAT && (w_fb_row == r_prev_row)) begin
            for (int i = 0; i < LANES; i++) begin
                w_fb_row[i] = (w_fb_idx_alt == 8'(i));
            end
        end
        w_accept = (w_pop != 4'd0) && (w_pop <= 4'(MAX_ACTIVE)) &&
                   (!NO_REPEAT || (w_cand != r_prev_row));
    end

    always_comb begin
        w_feedback = (^(r_lfsr & TAPS)) ^ entropy_in;
        if (seed_load) begin
            w_lfsr_nxt = (seed_value == '0) ? SEED : seed_value;
        end else if (r_lfsr == '0) begin
            w_lfsr_nxt = SEED;
        end else begin
            w_lfsr_nxt = {w_feedback, r_lfsr[LFSR_W-1:1]};
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_prev_nxt     = r_prev_row;
        w_fallback_nxt = r_fallback;
        w_tries_nxt    = r_tries;
        w_issued_nxt   = r_rows_issued;
        case (r_state)
            ST_GEN: begin
                if (w_accept) begin
                    w_row_nxt      = w_cand;
                    w_fallback_nxt = 1'b0;
                    w_tries_nxt    = '0;
                    w_state_nxt    = ST_HOLD;
                end else if (r_tries == TRY_W'(MAX_TRIES - 1)) begin
                    w_row_nxt      = w_fb_row;
                    w_fallback_nxt = 1'b1;
                    w_tries_nxt    = '0;
                    w_state_nxt    = ST_HOLD;
                end else begin
                    w_tries_nxt    = r_tries + TRY_W'(1);
                end
            end
            default: begin
                if (row_ready) begin
                    w_prev_nxt   = r_row;
                    w_issued_nxt = r_rows_issued + 16'd1;
                    w_state_nxt  = ST_GEN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_GEN;
            r_lfsr        <= SEED;
            r_row         <= '0;
            r_prev_row    <= '0;
            r_fallback    <= 1'b0;
            r_tries       <= '0;
            r_rows_issued <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_lfsr        <= w_lfsr_nxt;
            r_row         <= w_row_nxt;
            r_prev_row    <= w_prev_nxt;
            r_fallback    <= w_fallback_nxt;
            r_tries       <= w_tries_nxt;
            r_rows_issued <= w_issued_nxt;
        end
    end

    assign row_valid     = (r_state == ST_HOLD);
    assign row           = r_row;
    assign rows_issued   = r_rows_issued;
    assign fallback_used = r_fallback;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_tile_row_generator.sv
// Bench for tile_row_generator: cycle model + expected-row queue, table-driven density
// sweep, and hand sequences for reset, hold, seed, lockup and counter wrap.
module tb_tile_row_generator;

    localparam int         L    = 4;
    localparam int         W    = 24;
    localparam logic [W-1:0] SEED = 24'h694237;
    localparam logic [W-1:0] TAPS = 24'hE10001;

    logic         clk = 1'b0;
    logic         rst, entropy_in, seed_load, row_ready, ready_f;
    logic [W-1:0] seed_value;
    logic [1:0]   density, density_f;
    logic         row_valid, fallback_used, dbg_state;
    logic [L-1:0] row;
    logic [15:0]  rows_issued;
    logic         row_valid_f, fallback_used_f, dbg_state_f;
    logic [L-1:0] row_f;
    logic [15:0]  rows_issued_f;

    always #5 clk = ~clk;

    tile_row_generator dut (
        .clk(clk), .rst(rst), .entropy_in(entropy_in), .seed_load(seed_load),
        .seed_value(seed_value), .density(density), .row_ready(row_ready),
        .row_valid(row_valid), .row(row), .rows_issued(rows_issued),
        .fallback_used(fallback_used), .dbg_state(dbg_state)
    );

    tile_row_generator #(.MAX_ACTIVE(1), .MAX_TRIES(1)) dut_f (
        .clk(clk), .rst(rst), .entropy_in(entropy_in), .seed_load(seed_load),
        .seed_value(seed_value), .density(density_f), .row_ready(ready_f),
        .row_valid(row_valid_f), .row(row_f), .rows_issued(rows_issued_f),
        .fallback_used(fallback_used_f), .dbg_state(dbg_state_f)
    );

    typedef struct {
        logic [W-1:0] lfsr;
        logic         hold;
        int           tries;
        logic [L-1:0] prev;
        logic [L-1:0] row;
        logic         fb;
        logic [15:0]  issued;
    } model_t;

    typedef struct {
        logic [1:0] dens;
        int         n_rows;
        bit         need_fb;
        bit         need_onehot;
    } vec_t;

    model_t       m0, m1;
    logic [L:0]   exp_q[$];
    logic [L:0]   exp_q_f[$];
    int           n_tests = 0, n_fail = 0;
    logic         vd0 = 1'b0, vd1 = 1'b0, new_row0 = 1'b0;
    logic [L-1:0] last0 = '0, last1 = '0;
    int           rows_seen, fb_seen, onehot_bad;
    logic [L:0]   seq [2][100];
    vec_t         vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.lfsr = SEED; m.hold = 1'b0; m.tries = 0; m.prev = '0;
        m.row = '0; m.fb = 1'b0; m.issued = '0;
        return m;
    endfunction

    // Spec-level behaviour of one clock edge with rst low.
    function automatic model_t model_step(input model_t m, input logic [1:0] dens, input logic rdy,
                                          input int max_active, input int max_tries,
                                          output logic pushed);
        model_t       n;
        logic [L-1:0] cand, oh;
        int           pop, f;
        n = m;
        pushed = 1'b0;
        cand = '0;
        for (int i = 0; i < L; i++) begin
            case (dens)
                2'b00:   cand[i] = m.lfsr[3*i] & m.lfsr[3*i+1];
                2'b01:   cand[i] = m.lfsr[3*i];
                2'b10:   cand[i] = m.lfsr[3*i] & m.lfsr[3*i+1] & m.lfsr[3*i+2];
                default: cand[i] = (i == (int'(m.lfsr[W-1:W-8]) % L));
            endcase
        end
        pop = $countones(cand);
        f = int'(m.lfsr[7:0]) % L;
        oh = '0;
        oh[f] = 1'b1;
        if (oh == m.prev) begin
            oh = '0;
            oh[(f + 1) % L] = 1'b1;
        end
        if (!m.hold) begin
            if (pop >= 1 && pop <= max_active && cand != m.prev) begin
                n.row = cand; n.fb = 1'b0; n.tries = 0; n.hold = 1'b1; pushed = 1'b1;
            end else if (m.tries == max_tries - 1) begin
                n.row = oh; n.fb = 1'b1; n.tries = 0; n.hold = 1'b1; pushed = 1'b1;
            end else begin
                n.tries = m.tries + 1;
            end
        end else if (rdy) begin
            n.prev = m.row; n.issued = m.issued + 16'd1; n.hold = 1'b0;
        end
        if (seed_load)
            n.lfsr = (seed_value == '0) ? SEED : seed_value;
        else if (m.lfsr == '0)
            n.lfsr = SEED;
        else
            n.lfsr = {(^(m.lfsr & TAPS)) ^ entropy_in, m.lfsr[W-1:1]};
        return n;
    endfunction

    task automatic run_checks();
        logic [L:0] e;
        new_row0 = 1'b0;
        if (rst) begin
            check("rst_valid", {31'd0, row_valid}, 32'd0);
            check("rst_row", {28'd0, row}, 32'd0);
            check("rst_issued", {16'd0, rows_issued}, 32'd0);
            vd0 = 1'b0; vd1 = 1'b0; last0 = '0; last1 = '0;
            return;
        end
        check("valid", {31'd0, row_valid}, {31'd0, m0.hold});
        check("issued", {16'd0, rows_issued}, {16'd0, m0.issued});
        if (m0.hold) check("held_row", {27'd0, fallback_used, row}, {27'd0, m0.fb, m0.row});
        if (row_valid && !vd0) begin
            new_row0 = 1'b1;
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_row", {27'd0, fallback_used, row}, {27'd0, e});
            end
            check("popcount_1_2", {31'd0, ($countones(row) >= 1 && $countones(row) <= 2)}, 32'd1);
            check("no_repeat", {31'd0, (row != last0)}, 32'd1);
            rows_seen++;
            if (fallback_used) fb_seen++;
            if (density == 2'b11 && $countones(row) != 1) onehot_bad++;
        end
        if (row_valid && row_ready) last0 = row;
        vd0 = row_valid;

        check("f_valid", {31'd0, row_valid_f}, {31'd0, m1.hold});
        check("f_issued", {16'd0, rows_issued_f}, {16'd0, m1.issued});
        if (row_valid_f && !vd1) begin
            if (exp_q_f.size() == 0) begin
                check("f_sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q_f.pop_front();
                check("f_sb_row", {27'd0, fallback_used_f, row_f}, {27'd0, e});
            end
            check("f_onehot", {31'd0, ($countones(row_f) == 1)}, 32'd1);
            check("f_no_repeat", {31'd0, (row_f != last1)}, 32'd1);
        end
        if (row_valid_f && ready_f) last1 = row_f;
        vd1 = row_valid_f;
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic tick();
        logic p;
        @(posedge clk);
        if (rst) begin
            m0 = model_reset(); m1 = model_reset();
            exp_q.delete(); exp_q_f.delete();
        end else begin
            m0 = model_step(m0, density, row_ready, 2, 4, p);
            if (p) exp_q.push_back({m0.fb, m0.row});
            m1 = model_step(m1, density_f, ready_f, 1, 1, p);
            if (p) exp_q_f.push_back({m1.fb, m1.row});
        end
        @(negedge clk);
        run_checks();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int b;
        b = budget;
        while (!row_valid && b > 0) begin
            tick();
            b--;
        end
        check(name, {31'd0, row_valid}, 32'd1);
    endtask

    task automatic wait_rows(input string name, input int n, input int budget, input bit rand_ent);
        int b;
        b = budget;
        while (rows_seen < n && b > 0) begin
            if (rand_ent) entropy_in = 1'($urandom_range(0, 1));
            tick();
            b--;
        end
        check(name, {31'd0, (rows_seen >= n)}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{dens: 2'b00, n_rows: 5000, need_fb: 1'b0, need_onehot: 1'b0};
        vecs[1] = '{dens: 2'b01, n_rows: 5000, need_fb: 1'b0, need_onehot: 1'b0};
        vecs[2] = '{dens: 2'b10, n_rows: 5000, need_fb: 1'b1, need_onehot: 1'b0};
        vecs[3] = '{dens: 2'b11, n_rows: 5000, need_fb: 1'b0, need_onehot: 1'b1};

        rst = 1'b1; entropy_in = 1'b0; seed_load = 1'b0; seed_value = '0;
        density = 2'b00; row_ready = 1'b1; density_f = 2'b01; ready_f = 1'b1;
        rows_seen = 0; fb_seen = 0; onehot_bad = 0;

        // Reset, then hold a row with row_ready low.
        repeat (2) tick();
        rst = 1'b0;
        row_ready = 1'b0;
        check("post_rst_valid", {31'd0, row_valid}, 32'd0);
        wait_valid("first_row", 20);
        repeat (20) tick();
        check("hold_issued", {16'd0, rows_issued}, 32'd0);
        row_ready = 1'b1;
        tick();
        check("hs_issued", {16'd0, rows_issued}, 32'd1);
        check("hs_valid_drop", {31'd0, row_valid}, 32'd0);

        // Density sweep.
        for (int v = 0; v < 4; v++) begin
            density = vecs[v].dens;
            rows_seen = 0; fb_seen = 0; onehot_bad = 0;
            wait_rows("sweep_rows", vecs[v].n_rows, vecs[v].n_rows * 8, 1'b1);
            if (vecs[v].need_fb) check("sweep_fallback_seen", {31'd0, (fb_seen > 0)}, 32'd1);
            if (vecs[v].need_onehot) check("sweep_onehot", onehot_bad, 32'd0);
        end

        // Zero seed substitutes SEED.
        entropy_in = 1'b0;
        seed_load = 1'b1; seed_value = '0;
        tick();
        seed_load = 1'b0;
        check("seed_zero", dut.r_lfsr, SEED);

        // Same seed, no entropy: identical 100-row sequences.
        density = 2'b01;
        for (int run = 0; run < 2; run++) begin
            rst = 1'b1;
            repeat (2) tick();
            rst = 1'b0; seed_load = 1'b1; seed_value = 24'h123456;
            tick();
            seed_load = 1'b0;
            rows_seen = 0;
            for (int g = 0; g < 2000 && rows_seen < 100; g++) begin
                tick();
                if (new_row0) seq[run][rows_seen - 1] = {fallback_used, row};
            end
            check("seed_run_rows", {31'd0, (rows_seen >= 100)}, 32'd1);
        end
        for (int k = 0; k < 100; k++) check("seed_repeat", {27'd0, seq[1][k]}, {27'd0, seq[0][k]});

        // Drive the LFSR into the all-zero state and watch it recover.
        seed_load = 1'b1; seed_value = 24'h000001;
        tick();
        check("lock_pre", dut.r_lfsr, 32'h000001);
        seed_load = 1'b0; entropy_in = 1'b1;
        tick();
        check("lock_zero", dut.r_lfsr, 32'h0);
        entropy_in = 1'b0;
        tick();
        check("lock_recover", dut.r_lfsr, SEED);
        rows_seen = 0;
        wait_rows("lock_continue", 5, 100, 1'b0);

        // Counter wrap from 16'hFFFF.
        row_ready = 1'b0;
        tick();
        force dut.r_rows_issued = 16'hFFFF;
        m0.issued = 16'hFFFF;
        tick();
        release dut.r_rows_issued;
        wait_valid("wrap_valid", 20);
        check("wrap_pre", {16'd0, rows_issued}, 32'h0000FFFF);
        row_ready = 1'b1;
        tick();
        check("wrap_zero", {16'd0, rows_issued}, 32'd0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_row_generator.md
Name: tile_row_generator

Overview:
- Parametrised successor to the 4-lane random tile source: an LFSR-driven generator that emits one row of LANES tile bits per valid/ready handshake.
- Adds selectable density modes, bounded rejection sampling, a deterministic fallback, a loadable seed, and zero-state recovery.
- Every issued row has between 1 and MAX_ACTIVE tiles. When NO_REPEAT=1, an issued row also never equals the previous issued row.
- Sits between the game timing logic (consumer) and the playfield row shifter.

Parameters:
- LANES, 4: number of tile lanes. Range 2..8.
- LFSR_W, 24: LFSR width. Must be >= 3*LANES and >= 8; elaboration error otherwise.
- TAPS, 24'hE10001: Fibonacci feedback mask. Feedback = XOR of reg bits where the mask bit is 1.
- SEED, 24'h694237: reset and substitute seed. Must be nonzero.
- MAX_ACTIVE, 2: maximum tiles per row. Range 1..LANES.
- MAX_TRIES, 4: number of rejected candidates before fallback is used. Range >= 1.
- NO_REPEAT, 1: when 1, a row equal to prev_row is rejected.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- entropy_in, input, 1: external noise bit (button timing), mixed into the LFSR every cycle.
- seed_load, input, 1: load seed_value into the LFSR this cycle.
- seed_value, input, LFSR_W: seed to load.
- density, input, 2: 00 = 25% per lane, 01 = 50%, 10 = 12.5%, 11 = single-tile mode.
- row_ready, input, 1: consumer accepts the row.
- row_valid, output, 1: row is valid.
- row, output, LANES: tile pattern. Bit i = lane i.
- rows_issued, output, 16: count of completed handshakes. Wraps modulo 2^16.
- fallback_used, output, 1: the current row came from the fallback path.

Behaviour:
- Reset (rst=1 at a clk edge): LFSR=SEED, state=GEN, tries=0, prev_row=0, row=0, row_valid=0, rows_issued=0, fallback_used=0. Reset wins over every other input and aborts any handshake in progress.
- LFSR advances every non-reset cycle in every state: reg <= {^(reg&TAPS) ^ entropy_in, reg[LFSR_W-1:1]}.
- seed_load=1 has priority over the advance: reg <= seed_value, or SEED if seed_value==0.
- If reg==0 at a clock edge (entropy lockup) and seed_load=0, reg <= SEED.
- Lane bits: b(i,k) = reg[(3*i+k) mod LFSR_W] for k in 0..2. Candidates are built from the current reg, combinationally.
- Candidate row by density:
  - 00: lane i = b(i,0) & b(i,1).
  - 01: lane i = b(i,0).
  - 10: lane i = b(i,0) & b(i,1) & b(i,2).
  - 11: one-hot at index reg[LFSR_W-1:LFSR_W-8] mod LANES.
- Candidate is acceptable iff popcount is in 1..MAX_ACTIVE and (NO_REPEAT=0 or candidate != prev_row).
- FSM, state GEN: row_valid=0. Each cycle evaluates one candidate.
  - If acceptable: row <= candidate, fallback_used <= 0, tries <= 0, go to HOLD.
  - Else if tries == MAX_TRIES-1: row <= fallback, fallback_used <= 1, tries <= 0, go to HOLD.
  - Else: tries++.
- Fallback = one-hot at index f = reg[7:0] mod LANES. If NO_REPEAT and that one-hot equals prev_row, use index (f+1) mod LANES. The fallback always satisfies the row constraints.
- FSM, state HOLD: row_valid=1. row and fallback_used are held stable until row_ready=1.
  - On the handshake (row_valid & row_ready at the edge): prev_row <= row, rows_issued++, go to GEN.
  - row_valid deasserts on the next cycle.
- Timing: at least 1 cycle in GEN, so at most one row every 2 cycles. Worst case MAX_TRIES cycles in GEN.
- row_ready while in GEN is ignored.
- density and seed_load changes take effect on the next GEN evaluation. A held row is never altered.
- rows_issued wraps from 16'hFFFF to 0.

Test Plan:
- Reset: assert rst for 2 cycles with row_ready=1 → during rst row_valid=0, row=0, rows_issued=0. row_valid first rises no earlier than the 2nd cycle after rst falls.
- Hold stability: row_ready=0 for 20 cycles after row_valid rises → row and fallback_used constant for all 20 cycles, rows_issued unchanged. Then row_ready=1 for one cycle → rows_issued=1, row_valid=0 on the following cycle.
- Constraint sweep: LANES=4, MAX_ACTIVE=2, NO_REPEAT=1, row_ready=1, random entropy_in, 5000 rows per density → every row has popcount 1..2 and differs from its predecessor. Density 11 rows are always one-hot. Density 10 shows fallback_used=1 at least once.
- Fallback forcing: MAX_ACTIVE=1, MAX_TRIES=1, density=01 → every row is one-hot and no two consecutive rows are equal. fallback_used=1 on every row whose candidate popcount != 1.
- Seed handling: seed_load=1 with seed_value=0 → LFSR=24'h694237 next cycle. Two runs with seed_value=24'h123456 and entropy_in=0 → identical 100-row sequences.
- Lockup and wrap: force the LFSR to 0 with entropy_in=0 → reg=SEED on the next cycle and generation continues. Preload rows_issued=16'hFFFF, complete one handshake → rows_issued=0.
